// File: rtl/sort4_ctrl.sv
// Four-element ascending sorter. One shared 4-bit magnitude comparator
// runs a fixed six-step bubble-sort schedule, doing one compare-and-swap
// per cycle. The result and the swap count are published together on the
// final step and held until the next sort completes.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// SORT  | one compare-and-swap step per cycle, steps 0..5
// DONE  | one-cycle completion pulse, then back to IDLE

module sort4_cmp4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       b_gt_o,
    output logic       b_lt_o,
    output logic       eq_o
);
    logic [3:0] e;
    logic [3:0] bg;
    logic [3:0] bl;

    // Bit-level magnitude compare: the most significant differing bit decides.
    always_comb begin
        e  = ~(a_i ^ b_i);
        bg = ~a_i & b_i;
        bl = a_i & ~b_i;
        b_gt_o = bg[3] | (e[3] & bg[2]) | (e[3] & e[2] & bg[1]) | (e[3] & e[2] & e[1] & bg[0]);
        b_lt_o = bl[3] | (e[3] & bl[2]) | (e[3] & e[2] & bl[1]) | (e[3] & e[2] & e[1] & bl[0]);
        eq_o   = &e;
    end
endmodule

module sort4_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] s3,
    output logic [2:0] swaps,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] w0_q, w1_q, w2_q, w3_q;
    logic [3:0] w0_d, w1_d, w2_d, w3_d;
    logic [2:0] step_q, step_d;
    logic [2:0] acc_q, acc_d;
    logic [3:0] s0_q, s1_q, s2_q, s3_q;
    logic [3:0] s0_d, s1_d, s2_d, s3_d;
    logic [2:0] swaps_q, swaps_d;

    logic [3:0] cmp_a, cmp_b;
    logic       b_gt, b_lt, eq;
    logic       do_swap;

    // Route the step's pair to the shared comparator: a = lower index, b = higher.
    always_comb begin
        cmp_a = w0_q;
        cmp_b = w1_q;
        case (step_q)
            3'd1, 3'd4: begin cmp_a = w1_q; cmp_b = w2_q; end
            3'd2:       begin cmp_a = w2_q; cmp_b = w3_q; end
            default:    begin cmp_a = w0_q; cmp_b = w1_q; end
        endcase
    end

    sort4_cmp4 u_cmp (
        .a_i    (cmp_a),
        .b_i    (cmp_b),
        .b_gt_o (b_gt),
        .b_lt_o (b_lt),
        .eq_o   (eq)
    );

    // Swap only on an unambiguous b-smaller result; ties never swap, keeping the sort stable.
    assign do_swap = b_lt & ~b_gt & ~eq;

    // Next-state, working-register and result-register logic.
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        step_d  = step_q;
        acc_d   = acc_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        swaps_d = swaps_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w0_d    = d0;
                    w1_d    = d1;
                    w2_d    = d2;
                    w3_d    = d3;
                    step_d  = 3'd0;
                    acc_d   = 3'd0;
                    state_d = SORT;
                end
            end
            SORT: begin
                step_d = step_q + 3'd1;
                if (do_swap) begin
                    acc_d = acc_q + 3'd1;
                    case (step_q)
                        3'd1, 3'd4: begin w1_d = cmp_b; w2_d = cmp_a; end
                        3'd2:       begin w2_d = cmp_b; w3_d = cmp_a; end
                        default:    begin w0_d = cmp_b; w1_d = cmp_a; end
                    endcase
                end
                if (step_q == 3'd5) begin
                    // Publish including this final step's swap.
                    s0_d    = w0_d;
                    s1_d    = w1_d;
                    s2_d    = w2_d;
                    s3_d    = w3_d;
                    swaps_d = acc_d;
                    step_d  = 3'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w0_q    <= 4'd0;
            w1_q    <= 4'd0;
            w2_q    <= 4'd0;
            w3_q    <= 4'd0;
            step_q  <= 3'd0;
            acc_q   <= 3'd0;
            s0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            s3_q    <= 4'd0;
            swaps_q <= 3'd0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            swaps_q <= swaps_d;
        end
    end

    assign s0    = s0_q;
    assign s1    = s1_q;
    assign s2    = s2_q;
    assign s3    = s3_q;
    assign swaps = swaps_q;
    assign busy  = (state_q == SORT);
    assign done  = (state_q == DONE);
endmodule
